// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared state encoding, IR half-select codes and timeout default for the fetch controller
package fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } fetch_state_e;

  localparam logic IR_LOW  = 1'b0;
  localparam logic IR_HIGH = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - per-byte memory stall counter; only present when FETCH_TIMEOUT_EN is defined
`ifdef FETCH_TIMEOUT_EN
module fetch_wait_timer
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  // Expiry fires on the stall cycle that would bring the count to the limit.
  localparam logic [7:0] LastCount = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = inc_i && !clr_i && (count_q == LastCount);

endmodule
`endif

// File: rtl/instruction_fetch_controller.sv
// rtl/instruction_fetch_controller.sv - two-byte instruction fetch sequencer; optional stall timeout under FETCH_TIMEOUT_EN
module instruction_fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Reset,
  input  logic FetchReq,
  input  logic Flush,
  input  logic MemReady,
  output logic MemRead,
  output logic PCInc,
  output logic IRWrite,
  output logic IRLH,
  output logic FetchDone,
  output logic Busy,
  output logic FetchError
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  fetch_state_e state_q, state_d;
  logic         in_read;
  logic         wait_expired;

  assign in_read = (state_q == RD_LO) || (state_q == RD_HI);

`ifdef FETCH_TIMEOUT_EN
  fetch_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .clr_i   (!in_read || MemReady || Flush),
    .inc_i   (in_read && !MemReady),
    .expire_o(wait_expired)
  );

  assign FetchError = (state_q == ERR);
`else
  assign wait_expired = 1'b0;
  assign FetchError   = 1'b0;
`endif

  // Write controls are Mealy so the IR captures on the edge the byte is presented.
  always_comb begin
    state_d   = state_q;
    MemRead   = 1'b0;
    IRWrite   = 1'b0;
    IRLH      = IR_LOW;
    PCInc     = 1'b0;
    FetchDone = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (FetchReq) state_d = RD_LO;
      end
      RD_LO: begin
        MemRead = 1'b1;
        IRLH    = IR_LOW;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCInc   = 1'b1;
          state_d = RD_HI;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      RD_HI: begin
        MemRead = 1'b1;
        IRLH    = IR_HIGH;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCInc   = 1'b1;
          state_d = DONE;
        end else if (wait_expired) begin
          state_d = ERR;
        end
      end
      DONE: begin
        FetchDone = 1'b1;
        state_d   = FetchReq ? RD_LO : IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (Flush) begin
      MemRead   = 1'b0;
      IRWrite   = 1'b0;
      PCInc     = 1'b0;
      FetchDone = 1'b0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb/tb_instruction_fetch_controller.sv - directed bench for the fetch controller; timeout steps built with FETCH_TIMEOUT_EN
module tb_instruction_fetch_controller;

  logic Clock, Reset, FetchReq, Flush, MemReady;
  logic MemRead, PCInc, IRWrite, IRLH, FetchDone, Busy, FetchError;
  logic [7:0]  MemData;
  logic [15:0] ir, exp_ir;

  int total = 0;
  int bad   = 0;
  int pc_pulses = 0;

  typedef struct {
    logic       half;
    logic [7:0] data;
  } wr_t;
  wr_t sb[$];

  // {MemRead, IRWrite, IRLH, PCInc, FetchDone, Busy, FetchError}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_LO_W  = 7'b1000010;
  localparam logic [6:0] V_LO_A  = 7'b1101010;
  localparam logic [6:0] V_HI_W  = 7'b1010010;
  localparam logic [6:0] V_HI_A  = 7'b1111010;
  localparam logic [6:0] V_DONE  = 7'b0000110;
  localparam logic [6:0] V_FLUSH = 7'b0000010;
  localparam logic [6:0] V_ERR   = 7'b0000011;
  localparam logic [6:0] M_ALL   = 7'h7f;
  localparam logic [6:0] M_NOLH  = 7'b1101111;

  instruction_fetch_controller #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .FetchReq  (FetchReq),
    .Flush     (Flush),
    .MemReady  (MemReady),
    .MemRead   (MemRead),
    .PCInc     (PCInc),
    .IRWrite   (IRWrite),
    .IRLH      (IRLH),
    .FetchDone (FetchDone),
    .Busy      (Busy),
    .FetchError(FetchError)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // External instruction register driven by the controller's write controls.
  always @(posedge Clock) begin
    if (IRWrite === 1'b1) begin
      if (IRLH) ir[15:8] <= MemData;
      else      ir[7:0]  <= MemData;
    end
  end

  function automatic logic [6:0] outs();
    return {MemRead, IRWrite, IRLH, PCInc, FetchDone, Busy, FetchError};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic req, input logic fl, input logic rdy,
                      input logic [7:0] d, input logic [6:0] exp, input logic [6:0] mask);
    wr_t w;
    FetchReq = req;
    Flush    = fl;
    MemReady = rdy;
    MemData  = d;
    if (exp[5]) begin
      sb.push_back('{exp[4], d});
      if (exp[4]) exp_ir[15:8] = d;
      else        exp_ir[7:0]  = d;
    end
    @(negedge Clock);
    chk(tag, 32'(outs() & mask), 32'(exp & mask));
    if (PCInc === 1'b1) pc_pulses++;
    if (IRWrite === 1'b1) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL %s_sb: observed unexpected IR write expected none", tag);
      end
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk({tag, "_wr"}, {23'd0, IRLH, MemData}, {23'd0, w.half, w.data});
      end
    end
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; FetchReq = 1'b0; Flush = 1'b0; MemReady = 1'b0; MemData = 8'h00;
    ir = 16'h0000; exp_ir = 16'h0000;
    #2;
    chk("reset_outs", 32'(outs()), 32'(V_IDLE));
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1;

    // zero-wait fetch 0x34, 0x12
    pc_pulses = 0;
    step("zw_req",  1, 0, 1, 8'h00, V_IDLE, M_ALL);
    step("zw_lo",   0, 0, 1, 8'h34, V_LO_A, M_ALL);
    step("zw_hi",   0, 0, 1, 8'h12, V_HI_A, M_ALL);
    step("zw_done", 0, 0, 0, 8'h00, V_DONE, M_ALL);
    step("zw_idle", 0, 0, 0, 8'h00, V_IDLE, M_ALL);
    chk("zw_ir", 32'(ir), 32'h1234);
    chk("zw_pc", pc_pulses, 2);

    // three waits on the low byte, two on the high byte
    pc_pulses = 0;
    step("ws_req",  1, 0, 0, 8'h00, V_IDLE, M_ALL);
    for (int i = 0; i < 3; i++) step("ws_lo_w", 0, 0, 0, 8'hee, V_LO_W, M_ALL);
    step("ws_lo",   0, 0, 1, 8'hcd, V_LO_A, M_ALL);
    for (int i = 0; i < 2; i++) step("ws_hi_w", 0, 0, 0, 8'hee, V_HI_W, M_ALL);
    step("ws_hi",   0, 0, 1, 8'hab, V_HI_A, M_ALL);
    step("ws_done", 0, 0, 0, 8'h00, V_DONE, M_ALL);
    chk("ws_ir", 32'(ir), 32'(exp_ir));
    chk("ws_pc", pc_pulses, 2);

    // back-to-back with FetchReq held
    pc_pulses = 0;
    step("bb_req",   1, 0, 1, 8'h00, V_IDLE, M_ALL);
    step("bb_lo1",   1, 0, 1, 8'h11, V_LO_A, M_ALL);
    step("bb_hi1",   1, 0, 1, 8'h22, V_HI_A, M_ALL);
    step("bb_done1", 1, 0, 1, 8'h00, V_DONE, M_ALL);
    chk("bb_ir1", 32'(ir), 32'h2211);
    step("bb_lo2",   1, 0, 1, 8'h33, V_LO_A, M_ALL);
    step("bb_hi2",   0, 0, 1, 8'h44, V_HI_A, M_ALL);
    step("bb_done2", 0, 0, 0, 8'h00, V_DONE, M_ALL);
    step("bb_idle",  0, 0, 0, 8'h00, V_IDLE, M_ALL);
    chk("bb_ir2", 32'(ir), 32'h4433);
    chk("bb_pc", pc_pulses, 4);

    // flush in RD_HI with MemReady and FetchReq high
    pc_pulses = 0;
    step("fl_req",   1, 0, 0, 8'h00, V_IDLE,  M_ALL);
    step("fl_lo",    0, 0, 1, 8'h5a, V_LO_A,  M_ALL);
    step("fl_hi",    1, 1, 1, 8'ha5, V_FLUSH, M_NOLH);
    step("fl_idle",  0, 0, 1, 8'h00, V_IDLE,  M_ALL);
    chk("fl_ir", 32'(ir), 32'h445a);
    chk("fl_pc", pc_pulses, 1);

    // asynchronous reset between edges while in RD_LO
    pc_pulses = 0;
    step("ar_req", 1, 0, 0, 8'h00, V_IDLE, M_ALL);
    FetchReq = 1'b0; MemReady = 1'b0;
    #2;
    chk("ar_pre", 32'(outs()), 32'(V_LO_W));
    Reset = 1'b0;
    #1;
    chk("ar_outs", 32'(outs()), 32'(V_IDLE));
    MemReady = 1'b1;
    #1;
    chk("ar_busy", 32'(Busy), 32'd0);
    chk("ar_rdy_outs", 32'(outs()), 32'(V_IDLE));
    @(negedge Clock); MemReady = 1'b0; Reset = 1'b1;
    @(posedge Clock); #1;
    step("ar2_req",  1, 0, 1, 8'h00, V_IDLE, M_ALL);
    step("ar2_lo",   0, 0, 1, 8'h78, V_LO_A, M_ALL);
    step("ar2_hi",   0, 0, 1, 8'h56, V_HI_A, M_ALL);
    step("ar2_done", 0, 0, 0, 8'h00, V_DONE, M_ALL);
    chk("ar2_ir", 32'(ir), 32'h5678);
    chk("ar2_pc", pc_pulses, 2);

`ifdef FETCH_TIMEOUT_EN
    // timeout after 4 stall cycles, held until Flush
    step("to_req", 1, 0, 0, 8'h00, V_IDLE, M_ALL);
    for (int i = 0; i < 4; i++) step("to_wait", 0, 0, 0, 8'h00, V_LO_W, M_ALL);
    for (int i = 0; i < 3; i++) step("to_err", 1, 0, 1, 8'h00, V_ERR, M_ALL);
    step("to_flush", 0, 1, 0, 8'h00, V_ERR, M_ALL);
    step("to_idle",  0, 0, 0, 8'h00, V_IDLE, M_ALL);

    // byte arrives on the 4th cycle: accepted, no error
    step("tb_req", 1, 0, 0, 8'h00, V_IDLE, M_ALL);
    for (int i = 0; i < 3; i++) step("tb_wait", 0, 0, 0, 8'h00, V_LO_W, M_ALL);
    step("tb_lo", 0, 0, 1, 8'h9c, V_LO_A, M_ALL);
    for (int i = 0; i < 3; i++) step("tb_hwait", 0, 0, 0, 8'h00, V_HI_W, M_ALL);
    step("tb_hi", 0, 0, 1, 8'h8b, V_HI_A, M_ALL);
    step("tb_done", 0, 0, 0, 8'h00, V_DONE, M_ALL);
    chk("tb_ir", 32'(ir), 32'h8b9c);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
